// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, waits out the memory read delay, and
// queues {pc, instr} pairs in a small prefetch FIFO for decode.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ADDR    | pc on imem_addr; halt if past end of memory, else start wait
// WAIT    | down-count memory read delay, leave on terminal count
// CAPTURE | push {pc, imem_instr} when FIFO has room, then advance pc
// HALT    | pc ran off populated memory; hold until redirect or reset
module instr_fetch_unit #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int RESET_PC   = 0,
    parameter int PC_STEP    = 4,
    parameter int MEM_WAIT   = 1,
    parameter int MEM_BYTES  = 160,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    output logic [ADDR_W-1:0]             imem_addr,
    input  logic [DATA_W-1:0]             imem_instr,
    input  logic                          redirect,
    input  logic [ADDR_W-1:0]             redirect_pc,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_W-1:0]             out_instr,
    output logic [ADDR_W-1:0]             out_pc,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          halted
);

    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int CW  = PW + 1;
    localparam int WCW = (MEM_WAIT < 2) ? 1 : $clog2(MEM_WAIT + 1);

    typedef enum logic [1:0] {
        S_ADDR,
        S_WAIT,
        S_CAPTURE,
        S_HALT
    } state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] pc, pc_nxt;
    logic [WCW-1:0]    wait_cnt, wait_nxt;

    logic [ADDR_W-1:0] fifo_pc    [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_instr [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count;
    logic              full, push, pop;

    assign full = (count == CW'(FIFO_DEPTH));
    // A redirect discards any pop in the same cycle; push is gated in the FSM.
    assign pop  = (count != '0) && out_ready && !redirect;

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        wait_nxt  = wait_cnt;
        push      = 1'b0;
        if (redirect) begin
            state_nxt = S_ADDR;
            pc_nxt    = redirect_pc & ~ADDR_W'(3);
        end else begin
            case (state)
                S_ADDR: begin
                    if (pc >= ADDR_W'(MEM_BYTES)) begin
                        state_nxt = S_HALT;
                    end else if (MEM_WAIT == 0) begin
                        state_nxt = S_CAPTURE;
                    end else begin
                        wait_nxt  = WCW'(MEM_WAIT);
                        state_nxt = S_WAIT;
                    end
                end
                S_WAIT: begin
                    wait_nxt = wait_cnt - WCW'(1);
                    if (wait_cnt == WCW'(1)) state_nxt = S_CAPTURE;
                end
                S_CAPTURE: begin
                    // Fullness is judged before any same-cycle pop.
                    if (!full) begin
                        push      = 1'b1;
                        pc_nxt    = pc + ADDR_W'(PC_STEP);
                        state_nxt = S_ADDR;
                    end
                end
                S_HALT: begin
                    state_nxt = S_HALT;
                end
                default: state_nxt = S_ADDR;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_ADDR;
            pc       <= ADDR_W'(RESET_PC);
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            pc       <= pc_nxt;
            wait_cnt <= wait_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || redirect) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && push) begin
            fifo_pc[wr_ptr]    <= pc;
            fifo_instr[wr_ptr] <= imem_instr;
        end
    end

    assign imem_addr  = pc;
    assign out_valid  = (count != '0);
    assign out_pc     = fifo_pc[rd_ptr];
    assign out_instr  = fifo_instr[rd_ptr];
    assign fifo_count = count;
    assign halted     = (state == S_HALT);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a main instance with 40-word memory
// and a second instance with a 5-word memory to exercise the halt path.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // main instance
    logic        reset, redirect, out_ready;
    logic [31:0] imem_addr, imem_instr, redirect_pc, out_instr, out_pc;
    logic        out_valid, halted;
    logic [2:0]  fifo_count;

    // short-memory instance
    logic        reset_h, redirect_h, out_ready_h;
    logic [31:0] imem_addr_h, imem_instr_h, redirect_pc_h, out_instr_h, out_pc_h;
    logic        out_valid_h, halted_h;
    logic [2:0]  fifo_count_h;

    int tests = 0;
    int fails = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'd0:   return 32'h5800_0000;
            32'd4:   return 32'h5808_0003;
            32'd12:  return 32'h3880_0000;
            32'd16:  return 32'h0800_0002;
            default: return 32'hC0DE_0000 | a;
        endcase
    endfunction

    always_comb imem_instr   = mem_word(imem_addr);
    always_comb imem_instr_h = mem_word(imem_addr_h);

    instr_fetch_unit #(.MEM_WAIT(1), .MEM_BYTES(160), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_instr(imem_instr),
        .redirect(redirect), .redirect_pc(redirect_pc), .out_valid(out_valid),
        .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
        .fifo_count(fifo_count), .halted(halted)
    );

    instr_fetch_unit #(.MEM_WAIT(1), .MEM_BYTES(20), .FIFO_DEPTH(4)) dut_h (
        .clk(clk), .reset(reset_h), .imem_addr(imem_addr_h), .imem_instr(imem_instr_h),
        .redirect(redirect_h), .redirect_pc(redirect_pc_h), .out_valid(out_valid_h),
        .out_ready(out_ready_h), .out_instr(out_instr_h), .out_pc(out_pc_h),
        .fifo_count(fifo_count_h), .halted(halted_h)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Pulse reset for one edge and release it; edge count restarts from here.
    task automatic do_reset();
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; redirect = 1'b0; redirect_pc = '0; out_ready = 1'b1;
        reset_h = 1'b1; redirect_h = 1'b0; redirect_pc_h = '0; out_ready_h = 1'b1;
        tick(2);
        check("rst_valid", out_valid, 0);
        check("rst_count", fifo_count, 0);
        check("rst_halted", halted, 0);
        check("rst_addr", imem_addr, 0);
        check("rst_halted_h", halted_h, 0);

        // 1: basic fetch, ready high
        reset = 1'b0;
        tick(2);
        check("t1_no_early_valid", out_valid, 0);
        tick(1);
        check("t1_valid_e3", out_valid, 1);
        check("t1_pc_e3", out_pc, 0);
        check("t1_instr_e3", out_instr, 32'h5800_0000);
        check("t1_addr_e3", imem_addr, 4);
        tick(1);
        check("t1_drained_e4", out_valid, 0);
        tick(2);
        check("t1_pc_e6", out_pc, 4);
        check("t1_instr_e6", out_instr, 32'h5808_0003);
        check("t1_addr_e6", imem_addr, 8);

        // 2: backpressure fills the FIFO, then drains in order
        out_ready = 1'b0;
        do_reset();
        tick(18);
        check("t2_full_count", fifo_count, 4);
        check("t2_hold_addr", imem_addr, 16);
        check("t2_head0", out_pc, 0);
        out_ready = 1'b1;
        tick(1);
        check("t2_no_push_full", fifo_count, 3);
        check("t2_head4", out_pc, 4);
        tick(1);
        check("t2_pushpop_count", fifo_count, 3);
        check("t2_head8", out_pc, 8);
        tick(1);
        check("t2_head12", out_pc, 12);
        tick(1);
        check("t2_head16", out_pc, 16);
        check("t2_instr16", out_instr, 32'h0800_0002);
        check("t2_count1", fifo_count, 1);

        // 3: redirect with two entries queued flushes and realigns pc
        out_ready = 1'b0;
        do_reset();
        tick(6);
        check("t3_pre_count", fifo_count, 2);
        redirect = 1'b1; redirect_pc = 32'h0E; out_ready = 1'b1;
        tick(1);
        redirect = 1'b0; out_ready = 1'b0;
        check("t3_flush_valid", out_valid, 0);
        check("t3_flush_count", fifo_count, 0);
        check("t3_addr", imem_addr, 32'h0C);
        tick(2);
        check("t3_no_stray_push", out_valid, 0);
        tick(1);
        check("t3_pc", out_pc, 32'h0C);
        check("t3_instr", out_instr, 32'h3880_0000);

        // 6: simultaneous pop and push keeps count, head advances
        tick(3);
        check("t6_count2", fifo_count, 2);
        tick(2);
        out_ready = 1'b1;
        tick(1);
        check("t6_count_same", fifo_count, 2);
        check("t6_head", out_pc, 32'h10);

        // 5: reset mid-WAIT with three entries queued
        out_ready = 1'b0;
        do_reset();
        tick(10);
        check("t5_pre_count", fifo_count, 3);
        reset = 1'b1;
        tick(1);
        check("t5_valid", out_valid, 0);
        check("t5_count", fifo_count, 0);
        check("t5_halted", halted, 0);
        check("t5_addr", imem_addr, 0);
        reset = 1'b0;
        tick(3);
        check("t5_restart_pc", out_pc, 0);
        check("t5_restart_valid", out_valid, 1);

        // 4: halt at end of short memory, then resume via redirect
        reset_h = 1'b0;
        tick(15);
        check("t4_last_pc", out_pc_h, 16);
        check("t4_not_halted_yet", halted_h, 0);
        tick(1);
        check("t4_halted", halted_h, 1);
        check("t4_addr20", imem_addr_h, 20);
        tick(5);
        check("t4_still_halted", halted_h, 1);
        check("t4_addr_hold", imem_addr_h, 20);
        check("t4_no_push", fifo_count_h, 0);
        redirect_h = 1'b1; redirect_pc_h = 32'd8;
        tick(1);
        redirect_h = 1'b0;
        check("t4_unhalt", halted_h, 0);
        check("t4_resume_addr", imem_addr_h, 8);
        tick(3);
        check("t4_resume_valid", out_valid_h, 1);
        check("t4_resume_pc", out_pc_h, 8);
        check("t4_resume_instr", out_instr_h, 32'hC0DE_0008);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
